// File: rtl/pipeline_stage_controller.sv
// pipeline_stage_controller: generates per-stage pipeline-register write
// enables and valid flags for a NUM_STAGES deep CPU datapath, either as a
// one-hot token (sequential, PIPELINED=0) or as an overlapped pipeline with
// stall bubbles and branch flushes (PIPELINED=1).
// After reset the block holds stage_reset_n low for two cycles (INIT) before
// running. Every output is decoded from registered state only.
// Optional feature: define PIPELINE_PERF_COUNTER_EN to add the cycle_count and
// retired_count performance counters.
module pipeline_stage_controller #(
  parameter int NUM_STAGES   = 5,
  parameter int PIPELINED    = 0,
  parameter int RAM_STAGE    = 3,
  parameter int REG_STAGE    = 4,
  parameter int STALL_STAGE  = 2,
  parameter int FLUSH_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall_req,
  input  logic                  flush_req,
  output logic [NUM_STAGES-1:0] stage_wren,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  pc_wren,
  output logic                  ram_wren,
  output logic                  reg_wren,
  output logic                  stage_reset_n
`ifdef PIPELINE_PERF_COUNTER_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           retired_count
`endif
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [NUM_STAGES-1:0] LP_ALL    = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] LP_TOKEN0 = {{(NUM_STAGES-1){1'b0}}, 1'b1};
  // Stages below STALL_STAGE hold on a stall.
  localparam logic [NUM_STAGES-1:0] LP_HOLD_MASK  = LP_ALL >> (NUM_STAGES - STALL_STAGE);
  // Stages above STALL_STAGE keep advancing on a stall.
  localparam logic [NUM_STAGES-1:0] LP_ADV_MASK   = ~(LP_ALL >> (NUM_STAGES - STALL_STAGE - 1));
  // Leading stages invalidated by a flush.
  localparam logic [NUM_STAGES-1:0] LP_FLUSH_MASK = LP_ALL >> (NUM_STAGES - FLUSH_STAGES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_init_cnt;
  logic                  w_init_nxt;
  // r_vec is the one-hot token in sequential mode, the valid vector otherwise.
  logic [NUM_STAGES-1:0] r_vec;
  logic [NUM_STAGES-1:0] w_vec_nxt;
  logic [NUM_STAGES-1:0] r_wren;
  logic [NUM_STAGES-1:0] w_wren_nxt;
  logic [NUM_STAGES-1:0] w_shift;
  logic [NUM_STAGES-1:0] w_rotate;
  logic                  w_run;

  assign w_shift  = {r_vec[NUM_STAGES-2:0], 1'b1};
  assign w_rotate = {r_vec[NUM_STAGES-2:0], r_vec[NUM_STAGES-1]};

  // State register: controller state, INIT counter, token/valid and enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 1'b0;
      r_vec      <= (PIPELINED != 0) ? '0 : LP_TOKEN0;
      r_wren     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_nxt;
      r_vec      <= w_vec_nxt;
      r_wren     <= w_wren_nxt;
    end
  end

  // Next-state logic: INIT sequencing, token rotation or pipeline advance.
  always_comb begin
    w_state_nxt = r_state;
    w_init_nxt  = r_init_cnt;
    w_vec_nxt   = r_vec;
    w_wren_nxt  = r_wren;
    case (r_state)
      ST_INIT: begin
        w_init_nxt = 1'b1;
        if (r_init_cnt) begin
          w_state_nxt = ST_RUN;
          w_vec_nxt   = (PIPELINED != 0) ? w_shift : r_vec;
          w_wren_nxt  = (PIPELINED != 0) ? LP_ALL : r_vec;
        end
      end
      ST_RUN: begin
        if (PIPELINED != 0) begin
          if (flush_req) begin
            w_vec_nxt  = w_shift & ~LP_FLUSH_MASK;
            w_wren_nxt = LP_ALL;
          end else if (stall_req) begin
            // Front stages hold, STALL_STAGE gets a bubble, the rest drain.
            w_vec_nxt  = (r_vec & LP_HOLD_MASK) | (w_shift & LP_ADV_MASK);
            w_wren_nxt = ~LP_HOLD_MASK;
          end else begin
            w_vec_nxt  = w_shift;
            w_wren_nxt = LP_ALL;
          end
        end else begin
          if (flush_req) begin
            w_vec_nxt  = LP_TOKEN0;
            w_wren_nxt = LP_TOKEN0;
          end else if (stall_req) begin
            w_wren_nxt = '0;
          end else if (|r_wren) begin
            w_vec_nxt  = w_rotate;
            w_wren_nxt = w_rotate;
          end else begin
            // Coming out of a stall: the held stage has not been written yet.
            w_wren_nxt = r_vec;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_run         = (r_state == ST_RUN);
  assign stage_wren    = w_run ? r_wren : '0;
  assign stage_valid   = w_run ? r_vec : '0;
  assign pc_wren       = stage_wren[0];
  assign ram_wren      = stage_wren[RAM_STAGE] & stage_valid[RAM_STAGE];
  assign reg_wren      = stage_wren[REG_STAGE] & stage_valid[REG_STAGE];
  assign stage_reset_n = w_run;

`ifdef PIPELINE_PERF_COUNTER_EN
  // Performance counters: RUN cycles and instructions leaving the last stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else if (w_run) begin
      cycle_count <= cycle_count + 32'd1;
      if (stage_wren[NUM_STAGES-1] & stage_valid[NUM_STAGES-1]) begin
        retired_count <= retired_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_controller.sv
// Testbench for pipeline_stage_controller: one sequential and one pipelined
// instance with default geometry, directed scenarios plus randomized
// stall/flush traffic checked against a behavioural model.
module tb_pipeline_stage_controller;

  localparam int N  = 5;
  localparam int SS = 2;
  localparam int FS = 3;

  logic clk;
  logic reset_n;
  logic s_stall, s_flush, p_stall, p_flush;
  logic [N-1:0] s_wren, s_valid, p_wren, p_valid;
  logic s_pc, s_ram, s_reg, s_srn;
  logic p_pc, p_ram, p_reg, p_srn;
`ifdef PIPELINE_PERF_COUNTER_EN
  logic [31:0] s_cyc, s_ret, p_cyc, p_ret;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipeline_stage_controller #(.PIPELINED(0)) u_seq (
    .clk(clk), .reset_n(reset_n), .stall_req(s_stall), .flush_req(s_flush),
    .stage_wren(s_wren), .stage_valid(s_valid), .pc_wren(s_pc),
    .ram_wren(s_ram), .reg_wren(s_reg), .stage_reset_n(s_srn)
`ifdef PIPELINE_PERF_COUNTER_EN
    , .cycle_count(s_cyc), .retired_count(s_ret)
`endif
  );

  pipeline_stage_controller #(.PIPELINED(1)) u_pipe (
    .clk(clk), .reset_n(reset_n), .stall_req(p_stall), .flush_req(p_flush),
    .stage_wren(p_wren), .stage_valid(p_valid), .pc_wren(p_pc),
    .ram_wren(p_ram), .reg_wren(p_reg), .stage_reset_n(p_srn)
`ifdef PIPELINE_PERF_COUNTER_EN
    , .cycle_count(p_cyc), .retired_count(p_ret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  bit          m_run;
  int          m_icnt;
  int          s_pos;       // stage index holding the sequential token
  bit          s_wr;        // token stage is written this cycle
  logic [N-1:0] p_v;        // live instruction per stage
  bit          p_stalled;   // previous edge saw a stall (without flush)
  logic [31:0] m_cyc, m_ret;

  logic [N-1:0] e_s_wren, e_s_valid, e_p_wren, e_p_valid;
  logic [13:0]  e_s_all, e_p_all;

  function automatic logic [N-1:0] pipe_next(logic [N-1:0] v, bit st, bit fl);
    logic [N-1:0] r;
    logic prev;
    int j;
    r = '0;
    for (int i = 0; i < N; i++) begin
      j = (i == 0) ? 0 : i - 1;
      prev = (i == 0) ? 1'b1 : v[j];
      if (fl)                 r[i] = (i < FS) ? 1'b0 : prev;
      else if (st && i < SS)  r[i] = v[i];
      else if (st && i == SS) r[i] = 1'b0;
      else                    r[i] = prev;
    end
    return r;
  endfunction

  function automatic logic [N-1:0] pipe_wren(bit stalled);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !(stalled && i < SS);
    return r;
  endfunction

  assign e_s_wren  = (m_run && s_wr) ? (5'b00001 << s_pos) : 5'b00000;
  assign e_s_valid = m_run ? (5'b00001 << s_pos) : 5'b00000;
  assign e_p_wren  = m_run ? pipe_wren(p_stalled) : 5'b00000;
  assign e_p_valid = m_run ? p_v : 5'b00000;
  assign e_s_all = {e_s_wren, e_s_valid, e_s_wren[0], e_s_wren[3] & e_s_valid[3],
                    e_s_wren[4] & e_s_valid[4], m_run};
  assign e_p_all = {e_p_wren, e_p_valid, e_p_wren[0], e_p_wren[3] & e_p_valid[3],
                    e_p_wren[4] & e_p_valid[4], m_run};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 1'b0; m_icnt <= 0; s_pos <= 0; s_wr <= 1'b0;
      p_v <= '0; p_stalled <= 1'b0; m_cyc <= '0; m_ret <= '0;
    end else if (!m_run) begin
      if (m_icnt == 1) begin
        m_run <= 1'b1; s_pos <= 0; s_wr <= 1'b1;
        p_v <= 5'b00001; p_stalled <= 1'b0;
      end else begin
        m_icnt <= m_icnt + 1;
      end
    end else begin
      m_cyc <= m_cyc + 32'd1;
      if (e_p_wren[4] && e_p_valid[4]) m_ret <= m_ret + 32'd1;
      if (s_flush) begin
        s_pos <= 0; s_wr <= 1'b1;
      end else if (s_stall) begin
        s_wr <= 1'b0;
      end else begin
        if (s_wr) s_pos <= (s_pos + 1) % N;
        s_wr <= 1'b1;
      end
      p_v <= pipe_next(p_v, p_stall, p_flush);
      p_stalled <= p_stall && !p_flush;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    s_stall = 0; s_flush = 0; p_stall = 0; p_flush = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_wren, s_valid, s_pc, s_ram, s_reg, s_srn} !== 14'd0) begin
      n_errors++;
      $display("FAIL reset_seq_outputs: got %b expected %b", {s_wren, s_valid, s_pc, s_ram, s_reg, s_srn}, 14'd0);
    end
    n_checks++;
    if ({p_wren, p_valid, p_pc, p_ram, p_reg, p_srn} !== 14'd0) begin
      n_errors++;
      $display("FAIL reset_pipe_outputs: got %b expected %b", {p_wren, p_valid, p_pc, p_ram, p_reg, p_srn}, 14'd0);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({s_srn, p_srn, s_wren, p_wren} !== 12'd0) begin
      n_errors++;
      $display("FAIL init_cycle1: got %b expected %b", {s_srn, p_srn, s_wren, p_wren}, 12'd0);
    end
    @(negedge clk);
    n_checks++;
    if ({s_srn, p_srn, s_wren, p_wren, s_pc, p_pc} !== 14'd0) begin
      n_errors++;
      $display("FAIL init_cycle2: got %b expected %b", {s_srn, p_srn, s_wren, p_wren, s_pc, p_pc}, 14'd0);
    end
  endtask

  task automatic test_free_run();
    logic [N-1:0] seq_tab [6];
    logic [N-1:0] pipe_tab [6];
    seq_tab  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    pipe_tab = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11111};
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if ({s_srn, s_wren, s_valid, s_pc, s_ram, s_reg} !==
          {1'b1, seq_tab[k-1], seq_tab[k-1], (k == 1 || k == 6), (k == 4), (k == 5)}) begin
        n_errors++;
        $display("FAIL seq_free_run_c%0d: got srn=%b wren=%b valid=%b pc=%b ram=%b reg=%b expected wren=%b",
                 k, s_srn, s_wren, s_valid, s_pc, s_ram, s_reg, seq_tab[k-1]);
      end
      n_checks++;
      if ({p_srn, p_wren, p_valid, p_pc, p_ram, p_reg} !==
          {1'b1, 5'b11111, pipe_tab[k-1], 1'b1, (k >= 4), (k >= 5)}) begin
        n_errors++;
        $display("FAIL pipe_fill_c%0d: got srn=%b wren=%b valid=%b pc=%b ram=%b reg=%b expected valid=%b",
                 k, p_srn, p_wren, p_valid, p_pc, p_ram, p_reg, pipe_tab[k-1]);
      end
    end
  endtask

  task automatic test_seq_stall();
    bit found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (s_wren === 5'b00100) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL seq_stall_wait_token2: got %b expected %b within 10 cycles", s_wren, 5'b00100);
    end
    s_stall = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({s_wren, s_valid, s_pc} !== {5'b00000, 5'b00100, 1'b0}) begin
        n_errors++;
        $display("FAIL seq_stall_c%0d: got wren=%b valid=%b pc=%b expected wren=00000 valid=00100 pc=0",
                 c, s_wren, s_valid, s_pc);
      end
    end
    s_stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_wren !== 5'b00100) begin
      n_errors++;
      $display("FAIL seq_stall_resume: got %b expected %b", s_wren, 5'b00100);
    end
    @(negedge clk);
    n_checks++;
    if ({s_wren, s_ram} !== {5'b01000, 1'b1}) begin
      n_errors++;
      $display("FAIL seq_stall_advance: got wren=%b ram=%b expected wren=01000 ram=1", s_wren, s_ram);
    end
  endtask

  task automatic test_pipe_stall();
    n_checks++;
    if (p_valid !== 5'b11111) begin
      n_errors++;
      $display("FAIL pipe_stall_precond_full: got %b expected %b", p_valid, 5'b11111);
    end
    p_stall = 1'b1;
    @(negedge clk);
    p_stall = 1'b0;
    n_checks++;
    if ({p_wren, p_valid, p_pc, p_ram, p_reg} !== {5'b11100, 5'b11011, 1'b0, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL pipe_stall_bubble: got wren=%b valid=%b pc=%b ram=%b reg=%b expected 11100 11011 0 1 1",
               p_wren, p_valid, p_pc, p_ram, p_reg);
    end
    @(negedge clk);
    n_checks++;
    if ({p_wren, p_valid, p_ram, p_reg} !== {5'b11111, 5'b10111, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL pipe_stall_bubble_s3: got wren=%b valid=%b ram=%b reg=%b expected 11111 10111 0 1",
               p_wren, p_valid, p_ram, p_reg);
    end
    @(negedge clk);
    n_checks++;
    if ({p_valid, p_ram, p_reg} !== {5'b01111, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL pipe_stall_bubble_s4: got valid=%b ram=%b reg=%b expected 01111 1 0", p_valid, p_ram, p_reg);
    end
    @(negedge clk);
    n_checks++;
    if ({p_valid, p_reg} !== {5'b11111, 1'b1}) begin
      n_errors++;
      $display("FAIL pipe_stall_recovered: got valid=%b reg=%b expected 11111 1", p_valid, p_reg);
    end
  endtask

  task automatic test_flush_stall();
    s_stall = 1'b1; s_flush = 1'b1;
    p_stall = 1'b1; p_flush = 1'b1;
    @(negedge clk);
    s_stall = 1'b0; s_flush = 1'b0;
    p_stall = 1'b0; p_flush = 1'b0;
    n_checks++;
    if ({p_wren, p_valid, p_ram, p_reg} !== {5'b11111, 5'b11000, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL pipe_flush_wins: got wren=%b valid=%b ram=%b reg=%b expected 11111 11000 1 1",
               p_wren, p_valid, p_ram, p_reg);
    end
    n_checks++;
    if ({s_wren, s_valid, s_pc} !== {5'b00001, 5'b00001, 1'b1}) begin
      n_errors++;
      $display("FAIL seq_flush_wins: got wren=%b valid=%b pc=%b expected 00001 00001 1", s_wren, s_valid, s_pc);
    end
    @(negedge clk);
    n_checks++;
    if ({s_wren, p_valid} !== {5'b00010, 5'b10001}) begin
      n_errors++;
      $display("FAIL flush_followup: got seq_wren=%b pipe_valid=%b expected 00010 10001", s_wren, p_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_checks++;
      if ({s_wren, s_valid, s_pc, s_ram, s_reg, s_srn} !== e_s_all) begin
        n_errors++;
        $display("FAIL random_seq_c%0d: got %b expected %b", c,
                 {s_wren, s_valid, s_pc, s_ram, s_reg, s_srn}, e_s_all);
      end
      n_checks++;
      if ({p_wren, p_valid, p_pc, p_ram, p_reg, p_srn} !== e_p_all) begin
        n_errors++;
        $display("FAIL random_pipe_c%0d: got %b expected %b", c,
                 {p_wren, p_valid, p_pc, p_ram, p_reg, p_srn}, e_p_all);
      end
`ifdef PIPELINE_PERF_COUNTER_EN
      n_checks++;
      if ({p_cyc, p_ret} !== {m_cyc, m_ret}) begin
        n_errors++;
        $display("FAIL random_counters_c%0d: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                 c, p_cyc, p_ret, m_cyc, m_ret);
      end
`endif
      s_stall = ($urandom_range(0, 3) == 0);
      s_flush = ($urandom_range(0, 7) == 0);
      p_stall = ($urandom_range(0, 3) == 0);
      p_flush = ($urandom_range(0, 7) == 0);
    end
    s_stall = 0; s_flush = 0; p_stall = 0; p_flush = 0;
  endtask

  task automatic test_midrun_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (22) @(negedge clk);
    n_checks++;
    if ({p_valid, p_ram, p_reg} !== {5'b11111, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL midrun_precond: got valid=%b ram=%b reg=%b expected 11111 1 1", p_valid, p_ram, p_reg);
    end
`ifdef PIPELINE_PERF_COUNTER_EN
    n_checks++;
    if ({p_cyc, p_ret, s_cyc} !== {32'd20, 32'd16, 32'd20}) begin
      n_errors++;
      $display("FAIL perf_counts_20: got cyc=%0d ret=%0d seq_cyc=%0d expected 20 16 20", p_cyc, p_ret, s_cyc);
    end
`endif
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({p_wren, p_valid, p_pc, p_ram, p_reg, p_srn, s_wren, s_valid, s_pc, s_ram, s_reg, s_srn} !== 28'd0) begin
      n_errors++;
      $display("FAIL midrun_async_reset: got pipe=%b seq=%b expected all zero",
               {p_wren, p_valid, p_pc, p_ram, p_reg, p_srn}, {s_wren, s_valid, s_pc, s_ram, s_reg, s_srn});
    end
`ifdef PIPELINE_PERF_COUNTER_EN
    n_checks++;
    if ({p_cyc, p_ret, s_cyc, s_ret} !== 128'd0) begin
      n_errors++;
      $display("FAIL perf_reset_clear: got cyc=%0d ret=%0d expected 0 0", p_cyc, p_ret);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_seq_stall();
    test_pipe_stall();
    test_flush_stall();
    test_random();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_controller.md
PIPELINE_STAGE_CONTROLLER -- requirements
Module: pipeline_stage_controller

Interface
REQ-001 Parameter NUM_STAGES, default 5, SHALL set the number of pipeline stages (legal 2..8).
REQ-002 Parameter PIPELINED, default 0, SHALL select mode: 0 = sequential (one stage per cycle), 1 = overlapped pipeline.
REQ-003 Parameter RAM_STAGE, default 3, SHALL give the stage index whose activity enables RAM writes (< NUM_STAGES).
REQ-004 Parameter REG_STAGE, default 4, SHALL give the stage index whose activity enables register-file writes (< NUM_STAGES).
REQ-005 Parameter STALL_STAGE, default 2, SHALL give the first stage that receives a bubble on stall (1..NUM_STAGES-1).
REQ-006 Parameter FLUSH_STAGES, default 3, SHALL give how many leading stages a flush invalidates (1..NUM_STAGES).
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 stall_req  input  1  hold front stages (hazard).
REQ-010 flush_req  input  1  discard front stages (taken branch).
REQ-011 stage_wren  output  NUM_STAGES  per-stage pipeline-register write enable; bit 0 = PC/WB->IF register.
REQ-012 stage_valid  output  NUM_STAGES  stage holds a live instruction.
REQ-013 pc_wren  output  1  PC update enable.
REQ-014 ram_wren  output  1  RAM write qualifier.
REQ-015 reg_wren  output  1  register-file write qualifier.
REQ-016 stage_reset_n  output  1  synchronous clear for pipeline registers, active-low.

Function
REQ-017 After reset release the block SHALL spend 2 cycles in INIT (stage_reset_n=0, all enables 0), then enter RUN with stage_reset_n=1.
REQ-018 Sequential mode SHALL keep a one-hot token; stage_wren = token, stage_valid = token, advancing stage i -> i+1 each cycle, wrapping NUM_STAGES-1 -> 0.
REQ-019 Sequential mode: stall_req=1 SHALL freeze the token and drive stage_wren=0 that cycle.
REQ-020 Sequential mode: flush_req=1 SHALL move the token to stage 0 on the next edge; flush wins over stall.
REQ-021 Pipelined mode SHALL keep valid[NUM_STAGES-1:0]; each unstalled cycle valid[i+1]<=valid[i], valid[0]<=1, stage_wren all ones.
REQ-022 Pipelined mode: stall_req=1 SHALL clear stage_wren[0..STALL_STAGE-1] (hold), set valid[STALL_STAGE]<=0 (bubble), and advance stages > STALL_STAGE normally.
REQ-023 Pipelined mode: flush_req=1 SHALL set valid[0..FLUSH_STAGES-1]<=0 on the next edge while later stages advance; flush wins over simultaneous stall.
REQ-024 pc_wren SHALL equal stage_wren[0] in RUN.
REQ-025 ram_wren SHALL equal stage_wren[RAM_STAGE] & stage_valid[RAM_STAGE]; reg_wren likewise for REG_STAGE.
REQ-026 All outputs SHALL be registered or decoded from registered state only; no combinational path stall_req/flush_req -> ram_wren/reg_wren.

Reset
REQ-027 reset_n=0 SHALL immediately force: state INIT, token=stage 0, valid=0, stage_wren=0, stage_valid=0, pc_wren=0, ram_wren=0, reg_wren=0, stage_reset_n=0, counters 0.
REQ-028 Reset asserted mid-operation SHALL abort any in-flight write in the same cycle (ram_wren/reg_wren low asynchronously).

Configuration
REQ-029 With PIPELINE_PERF_COUNTER_EN defined, outputs cycle_count[31:0] (increments every RUN cycle) and retired_count[31:0] (increments when stage NUM_STAGES-1 is valid and written) SHALL exist, both wrapping 0xFFFFFFFF->0.
REQ-030 Without PIPELINE_PERF_COUNTER_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-031 Sequential, defaults: release reset -> stage_reset_n low cycles 1-2, then stage_wren 00001,00010,00100,01000,10000,00001; ram_wren only on 01000, reg_wren only on 10000.
REQ-032 Sequential: stall_req high 3 cycles while token=stage 2 -> stage_wren=0 for 3 cycles, then 00100 resumes.
REQ-033 Pipelined: 10 free cycles -> stage_valid fills 00001..11111 by cycle 5; reg_wren first high in cycle 5.
REQ-034 Pipelined full: stall 1 cycle -> stage_wren=11100, valid[2]=0; bubble reaches stage 4 two cycles later, reg_wren low that cycle only.
REQ-035 Pipelined: stall_req and flush_req together -> valid[2:0]=000 next cycle, stage_wren=11111 (flush wins).
REQ-036 PIPELINE_PERF_COUNTER_EN: preload-free run of 20 pipelined cycles -> cycle_count=20, retired_count=16; assert reset_n mid-run -> both read 0 immediately.
